// File: rtl/iq_rotator_pipe.sv
// Three-stage pipelined I/Q phase rotator with valid/enable flow control, conjugate mode,
// truncate/round requantisation, output saturation and a sticky saturation event counter.
module iq_rotator_pipe #(
    parameter int NB_DATA    = 8,
    parameter int NBF_DATA   = 6,
    parameter int NB_COEFF   = 8,
    parameter int NBF_COEFF  = 6,
    parameter int NB_OUTPUT  = 8,
    parameter int NBF_OUTPUT = 6,
    parameter int NB_SATCNT  = 16
) (
    input  logic                 clock,
    input  logic                 i_reset_n,
    input  logic                 i_enable,
    input  logic                 i_valid,
    input  logic [NB_DATA-1:0]   i_dataI,
    input  logic [NB_DATA-1:0]   i_dataQ,
    input  logic [NB_COEFF-1:0]  i_dataSin,
    input  logic [NB_COEFF-1:0]  i_dataCos,
    input  logic                 i_conj,
    input  logic                 i_round,
    input  logic                 i_sat_clr,
    output logic                 o_valid,
    output logic [NB_OUTPUT-1:0] o_dataRotatedI,
    output logic [NB_OUTPUT-1:0] o_dataRotatedQ,
    output logic                 o_sat_flag,
    output logic [NB_SATCNT-1:0] o_sat_count
);

    localparam int NB_P   = NB_DATA + NB_COEFF;
    localparam int NBF_P  = NBF_DATA + NBF_COEFF;
    localparam int NB_S   = NB_P + 1;
    localparam int NB_R   = NB_S + 1;
    localparam int D      = NBF_P - NBF_OUTPUT;
    localparam int RND_SH = (D > 0) ? D - 1 : 0;

    localparam logic signed [NB_R-1:0] RND_ADD = (D > 0) ? NB_R'(64'sd1 <<< RND_SH) : '0;
    localparam logic signed [NB_R-1:0] OUT_MAX = NB_R'((64'sd1 <<< (NB_OUTPUT - 1)) - 64'sd1);
    localparam logic signed [NB_R-1:0] OUT_MIN = ~OUT_MAX;
    localparam logic [NB_SATCNT-1:0]   SATCNT_MAX = '1;

    logic signed [NB_P-1:0] r_p_is, r_p_qc, r_p_ic, r_p_qs;
    logic                   r_v1, r_conj1, r_round1;
    logic signed [NB_S-1:0] r_sum_i, r_sum_q;
    logic                   r_v2, r_round2;
    logic [NB_OUTPUT-1:0]   r_out_i, r_out_q;
    logic                   r_v3, r_sat_flag;
    logic [NB_SATCNT-1:0]   r_sat_count;

    logic signed [NB_S-1:0] w_ext_is, w_ext_qc, w_ext_ic, w_ext_qs;
    logic signed [NB_S-1:0] w_sum_i, w_sum_q;
    logic [NB_OUTPUT:0]     w_req_i, w_req_q;
    logic                   w_sat_new;

    // Returns {saturated, requantised value}; the extra bit keeps the rounding add from wrapping.
    function automatic logic [NB_OUTPUT:0] requant(input logic signed [NB_S-1:0] sum,
                                                   input logic rnd);
        logic signed [NB_R-1:0] val;
        val = NB_R'(sum);
        if (rnd) begin
            val = val + RND_ADD;
        end
        val = val >>> D;
        if (val > OUT_MAX) begin
            requant = {1'b1, OUT_MAX[NB_OUTPUT-1:0]};
        end else if (val < OUT_MIN) begin
            requant = {1'b1, OUT_MIN[NB_OUTPUT-1:0]};
        end else begin
            requant = {1'b0, val[NB_OUTPUT-1:0]};
        end
    endfunction

    always_comb begin
        w_ext_is = NB_S'(r_p_is);
        w_ext_qc = NB_S'(r_p_qc);
        w_ext_ic = NB_S'(r_p_ic);
        w_ext_qs = NB_S'(r_p_qs);
        w_sum_i  = r_conj1 ? (w_ext_qc - w_ext_is) : (w_ext_is + w_ext_qc);
        w_sum_q  = r_conj1 ? (w_ext_ic + w_ext_qs) : (w_ext_ic - w_ext_qs);
        w_req_i  = requant(r_sum_i, r_round2);
        w_req_q  = requant(r_sum_q, r_round2);
        w_sat_new = r_v2 & (w_req_i[NB_OUTPUT] | w_req_q[NB_OUTPUT]);
    end

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_p_is     <= '0;
            r_p_qc     <= '0;
            r_p_ic     <= '0;
            r_p_qs     <= '0;
            r_v1       <= 1'b0;
            r_conj1    <= 1'b0;
            r_round1   <= 1'b0;
            r_sum_i    <= '0;
            r_sum_q    <= '0;
            r_v2       <= 1'b0;
            r_round2   <= 1'b0;
            r_out_i    <= '0;
            r_out_q    <= '0;
            r_v3       <= 1'b0;
            r_sat_flag <= 1'b0;
        end else if (i_enable) begin
            r_p_is     <= $signed(i_dataI) * $signed(i_dataSin);
            r_p_qc     <= $signed(i_dataQ) * $signed(i_dataCos);
            r_p_ic     <= $signed(i_dataI) * $signed(i_dataCos);
            r_p_qs     <= $signed(i_dataQ) * $signed(i_dataSin);
            r_v1       <= i_valid;
            r_conj1    <= i_conj;
            r_round1   <= i_round;
            r_sum_i    <= w_sum_i;
            r_sum_q    <= w_sum_q;
            r_v2       <= r_v1;
            r_round2   <= r_round1;
            r_out_i    <= w_req_i[NB_OUTPUT-1:0];
            r_out_q    <= w_req_q[NB_OUTPUT-1:0];
            r_v3       <= r_v2;
            r_sat_flag <= w_sat_new;
        end
    end

    // Clear is honoured even while the pipeline is stalled.
    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sat_count <= '0;
        end else if (i_sat_clr) begin
            r_sat_count <= '0;
        end else if (i_enable && w_sat_new && (r_sat_count != SATCNT_MAX)) begin
            r_sat_count <= r_sat_count + 1'b1;
        end
    end

    assign o_valid        = r_v3;
    assign o_dataRotatedI = r_out_i;
    assign o_dataRotatedQ = r_out_q;
    assign o_sat_flag     = r_sat_flag;
    assign o_sat_count    = r_sat_count;

endmodule

// File: doc/iq_rotator_pipe.md
Name: iq_rotator_pipe

Overview:
- Parametrised, pipelined successor of the single-stage IQ phase rotator. Multiplies an I/Q sample pair by a sin/cos pair and forms the rotated I/Q outputs.
- Adds valid/enable flow control, selectable rotation direction, selectable truncate or round-half-up requantisation, saturation, per-sample saturation flags and a saturating event counter.
- Sits between the receive filter output and the symbol slicer/phase-error loop.

Parameters:
- NB_DATA, 8, total bits of i_dataI/i_dataQ (signed)
- NBF_DATA, 6, fractional bits of data
- NB_COEFF, 8, total bits of i_dataSin/i_dataCos (signed)
- NBF_COEFF, 6, fractional bits of sin/cos
- NB_OUTPUT, 8, total bits of rotated outputs (signed)
- NBF_OUTPUT, 6, fractional bits of outputs; must satisfy NBF_OUTPUT <= NBF_DATA+NBF_COEFF
- NB_SATCNT, 16, width of saturation event counter

Ports:
- clock  in  1  system clock, rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_enable  in  1  pipeline advance; 0 freezes every register
- i_valid  in  1  input sample valid
- i_dataI, i_dataQ  in  NB_DATA  input sample, S(NB_DATA,NBF_DATA)
- i_dataSin, i_dataCos  in  NB_COEFF  rotation coefficients, S(NB_COEFF,NBF_COEFF)
- i_conj  in  1  0: normal rotation, 1: conjugate (sin term negated)
- i_round  in  1  0: truncate (floor), 1: round half up
- i_sat_clr  in  1  synchronous clear of o_sat_count
- o_valid  out  1  output valid
- o_dataRotatedI, o_dataRotatedQ  out  NB_OUTPUT  rotated sample, S(NB_OUTPUT,NBF_OUTPUT)
- o_sat_flag  out  1  1 when the current output has I or Q saturated
- o_sat_count  out  NB_SATCNT  count of saturated output samples

Behaviour:
- Reset (async, i_reset_n=0): all pipeline registers, o_valid, outputs, o_sat_flag and o_sat_count go to 0 immediately. Deassertion takes effect on the next rising edge. Reset mid-stream discards all in-flight samples.
- Pipeline has 3 stages, all advancing only when i_enable=1:
  - S1 registers the four products, each S(NB_DATA+NB_COEFF, NBF_DATA+NBF_COEFF), plus valid, i_conj and i_round.
  - S2 registers the sums, widened by 1 bit (S(NB_P+1,NBF_P)) so they never wrap.
    - conj=0: I = I·sin + Q·cos, Q = I·cos − Q·sin.
    - conj=1: I = Q·cos − I·sin, Q = I·cos + Q·sin.
  - S3 performs requantisation, registers the outputs and updates the flag and counter.
- Latency: 3 enabled cycles from i_valid to o_valid. With i_enable held at 1, throughput is 1 sample per cycle.
- i_enable=0: all stages, outputs, o_valid and o_sat_count hold their values. i_sat_clr is still honoured.
- Mode bits travel with their sample, so changing i_conj/i_round between samples affects only samples entered afterwards.
- Requantisation:
  - Drop D = NBF_P − NBF_OUTPUT LSBs.
  - If round=1 and D>0, first add 2^(D−1), in a width with 1 extra bit so the addition cannot wrap.
  - Floor-truncate.
  - If the result exceeds the output range, saturate to +max (0 followed by all 1s) or −min (1 followed by all 0s).
- Registers with o_valid=0 still compute, but o_sat_flag is forced to 0 and the counter does not increment.
- o_sat_flag = (I saturated OR Q saturated) AND valid, registered with the outputs.
- o_sat_count:
  - Increments by 1 on each enabled cycle whose S3 output has o_sat_flag=1.
  - Sticks at 2^NB_SATCNT−1 and never wraps.
  - i_sat_clr=1 sets it to 0 and has priority over a simultaneous increment.

Test Plan (defaults, all products S(16,12)):
- Identity: I=32 (0.5), Q=0, cos=64 (1.0), sin=0, conj=0, enable=1, valid pulse at cycle 0 -> o_valid at cycle 3; I_out=0, Q_out=32; sat_flag=0.
- Saturation and count: I=Q=sin=cos=127 -> I_out=127, Q_out=0, sat_flag=1, sat_count=1. Repeat ten samples -> count=11. Assert i_sat_clr together with a saturating sample -> count=0.
- Rounding: I=1, Q=0, cos=32, sin=0 -> Q_out=0 with round=0, Q_out=1 with round=1. With I=−1 -> Q_out=−1 with round=0, Q_out=0 with round=1.
- Conjugate and negative saturation:
  - I=0, Q=32, sin=64, cos=0, conj=0 -> I_out=0, Q_out=−32; conj=1 -> Q_out=+32.
  - I=Q=−128, sin=cos=127, conj=1 -> Q_out=−128 (sat), I_out=0.
- Stall: stream 5 distinct samples, drop i_enable for 4 cycles mid-stream -> outputs and o_valid frozen during the stall; the sequence resumes intact, with no sample lost or duplicated.
- Async reset: pulse i_reset_n low for half a clock with 3 samples in flight -> all outputs 0 immediately; no o_valid afterwards until new input arrives.
